// File: rtl/gb_frame_ctrl.sv
// Per-frame sequencer for the Gaussian-blur core. It starts the core over AXI-Lite,
// gates the pixel stream with TLAST, counts output beats and then polls ap_done.
`timescale 1ns/1ps
module gb_frame_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 20,
  parameter int IN_BEATS  = 316224,
  parameter int OUT_BEATS = 307200,
  parameter int CTRL_ADDR = 0
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [CNT_W-1:0]    in_cnt,
  output logic [CNT_W-1:0]    out_cnt,
  input  logic [7:0]          src_TDATA,
  input  logic                src_TVALID,
  output logic                src_TREADY,
  output logic [7:0]          arg_1_TDATA,
  output logic                arg_1_TVALID,
  input  logic                arg_1_TREADY,
  output logic                arg_1_TLAST,
  input  logic                arg_0_TVALID,
  input  logic                arg_0_TREADY,
  output logic                m_AWVALID,
  input  logic                m_AWREADY,
  output logic [ADDR_W-1:0]   m_AWADDR,
  output logic                m_WVALID,
  input  logic                m_WREADY,
  output logic [DATA_W-1:0]   m_WDATA,
  output logic [DATA_W/8-1:0] m_WSTRB,
  input  logic                m_BVALID,
  output logic                m_BREADY,
  output logic                m_ARVALID,
  input  logic                m_ARREADY,
  output logic [ADDR_W-1:0]   m_ARADDR,
  input  logic                m_RVALID,
  output logic                m_RREADY,
  input  logic [DATA_W-1:0]   m_RDATA
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_W, S_CFG_B, S_STREAM, S_DRAIN, S_POLL_AR, S_POLL_R, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_IN_LAST = CNT_W'(IN_BEATS - 1);
  localparam logic [CNT_W-1:0] LP_OUT_MAX = CNT_W'(OUT_BEATS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_ovf;
  logic             r_aw_done;
  logic             r_w_done;
  logic             w_start_acc;
  logic             w_in_beat;
  logic             w_out_beat;
  logic             w_cnt_window;
  logic             w_aw_ok;
  logic             w_w_ok;
  logic             w_unused_rdata;

  assign w_start_acc  = (r_state == S_IDLE) && start;
  assign w_in_beat    = arg_1_TVALID && arg_1_TREADY;
  assign w_out_beat   = arg_0_TVALID && arg_0_TREADY;
  assign w_cnt_window = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_aw_ok      = r_aw_done || m_AWREADY;
  assign w_w_ok       = r_w_done || m_WREADY;

  // Only ap_done (bit 1) of the control register matters when polling.
  assign w_unused_rdata = ^{m_RDATA[DATA_W-1:2], m_RDATA[0]};

  assign m_AWADDR    = ADDR_W'(CTRL_ADDR);
  assign m_ARADDR    = ADDR_W'(CTRL_ADDR);
  assign m_WDATA     = DATA_W'(1);
  assign m_WSTRB     = '1;
  assign arg_1_TDATA = src_TDATA;
  assign arg_1_TLAST = (r_in_cnt == LP_IN_LAST);
  assign in_cnt      = r_in_cnt;
  assign out_cnt     = r_out_cnt;
  assign ovf         = r_ovf;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (w_start_acc) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_in_beat) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end
      // Beats past the frame size, or outside the counting window, are sticky errors.
      if (w_out_beat) begin
        if (w_cnt_window && (r_out_cnt != LP_OUT_MAX)) begin
          r_out_cnt <= r_out_cnt + 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // AW and W handshake independently; each flag remembers its own acceptance.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == S_CFG_W) begin
      if (m_AWVALID && m_AWREADY) begin
        r_aw_done <= 1'b1;
      end
      if (m_WVALID && m_WREADY) begin
        r_w_done <= 1'b1;
      end
    end else begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    src_TREADY   = 1'b0;
    arg_1_TVALID = 1'b0;
    m_AWVALID    = 1'b0;
    m_WVALID     = 1'b0;
    m_BREADY     = 1'b0;
    m_ARVALID    = 1'b0;
    m_RREADY     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CFG_W;
        end
      end
      S_CFG_W: begin
        m_AWVALID = !r_aw_done;
        m_WVALID  = !r_w_done;
        if (w_aw_ok && w_w_ok) begin
          w_state_nxt = S_CFG_B;
        end
      end
      S_CFG_B: begin
        m_BREADY = 1'b1;
        if (m_BVALID) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        arg_1_TVALID = src_TVALID;
        src_TREADY   = arg_1_TREADY;
        if (w_in_beat && arg_1_TLAST) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_out_cnt == LP_OUT_MAX) begin
          w_state_nxt = S_POLL_AR;
        end
      end
      S_POLL_AR: begin
        m_ARVALID = 1'b1;
        if (m_ARREADY) begin
          w_state_nxt = S_POLL_R;
        end
      end
      S_POLL_R: begin
        m_RREADY = 1'b1;
        if (m_RVALID) begin
          w_state_nxt = m_RDATA[1] ? S_DONE : S_POLL_AR;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gb_frame_ctrl.sv
// Randomized scoreboard bench for gb_frame_ctrl with a small frame size; drivers
// act 1ns after the rising edge and the monitor samples on the falling edge.
`timescale 1ns/1ps
module tb_gb_frame_ctrl;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 8;
  localparam int IN_BEATS  = 12;
  localparam int OUT_BEATS = 4;
  localparam int CTRL_ADDR = 0;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic                start = 1'b0;
  logic                busy, done, ovf;
  logic [CNT_W-1:0]    in_cnt, out_cnt;
  logic [7:0]          src_TDATA = '0;
  logic                src_TVALID = 1'b0;
  logic                src_TREADY;
  logic [7:0]          arg_1_TDATA;
  logic                arg_1_TVALID, arg_1_TLAST;
  logic                arg_1_TREADY = 1'b0;
  logic                arg_0_TVALID = 1'b0, arg_0_TREADY = 1'b0;
  logic                m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY;
  logic                m_AWREADY = 1'b0, m_WREADY = 1'b0, m_BVALID = 1'b0;
  logic                m_ARREADY = 1'b0, m_RVALID = 1'b0;
  logic [ADDR_W-1:0]   m_AWADDR, m_ARADDR;
  logic [DATA_W-1:0]   m_WDATA;
  logic [DATA_W/8-1:0] m_WSTRB;
  logic [DATA_W-1:0]   m_RDATA = '0;

  gb_frame_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .IN_BEATS(IN_BEATS), .OUT_BEATS(OUT_BEATS), .CTRL_ADDR(CTRL_ADDR)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .busy(busy), .done(done), .ovf(ovf), .in_cnt(in_cnt), .out_cnt(out_cnt),
    .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY),
    .arg_1_TDATA(arg_1_TDATA), .arg_1_TVALID(arg_1_TVALID),
    .arg_1_TREADY(arg_1_TREADY), .arg_1_TLAST(arg_1_TLAST),
    .arg_0_TVALID(arg_0_TVALID), .arg_0_TREADY(arg_0_TREADY),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA)
  );

  typedef struct {
    int in_c;
    int out_c;
    int ovf_e;
    int polls;
  } frame_t;

  int checks = 0;
  int failures = 0;

  // Per-frame stimulus configuration
  int aw_delay = 0, w_delay = 0, out_n = 0, out_after = 1, gap_pct = 0, tr_mode = 0;
  bit rd_rand = 0, src_en = 0, out_en = 0;

  // Reference model state, advanced only by observed handshakes
  int cyc = 0, acc_in = 0, src_k = 0, out_seen = 0, zr_left = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, frames_done = 0;
  int ns_idx = -100, tl_idx = -1, out4_idx = -1, first_ar_idx = -1;
  bit pend = 0;
  logic [8:0] in_q[$];
  frame_t     fr_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever #5 ap_clk = ~ap_clk;

  initial begin
    #800000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  // Pixel source: a new pixel is only issued after the previous one was taken,
  // and once TVALID is raised it is held until accepted.
  initial begin : src_drv
    bit hs;
    forever begin
      @(negedge ap_clk);
      hs = src_TVALID && src_TREADY && ap_rst_n;
      @(posedge ap_clk);
      #1;
      if (hs) begin
        pend = 0;
        src_TVALID = 1'b0;
      end
      if (!src_en) begin
        pend = 0;
        src_TVALID = 1'b0;
      end else begin
        if (!pend && src_k < IN_BEATS) begin
          src_TDATA = 8'($urandom);
          in_q.push_back({(src_k == IN_BEATS - 1), src_TDATA});
          src_k++;
          pend = 1;
        end
        if (pend && !src_TVALID) src_TVALID = ($urandom_range(0, 99) >= gap_pct);
      end
    end
  end

  initial begin : core_drv
    forever begin
      @(posedge ap_clk);
      #1;
      case (tr_mode)
        0:       arg_1_TREADY = 1'b1;
        1:       arg_1_TREADY = ~arg_1_TREADY;
        default: arg_1_TREADY = 1'($urandom_range(0, 1));
      endcase
      arg_0_TREADY = 1'b1;
      arg_0_TVALID = out_en && (out_seen < out_n) && (acc_in >= out_after);
    end
  end

  initial begin : axi_drv
    int awc, wc;
    awc = 0;
    wc = 0;
    forever begin
      @(posedge ap_clk);
      #1;
      if (m_AWVALID) begin m_AWREADY = (awc >= aw_delay); awc++; end
      else begin m_AWREADY = 1'b0; awc = 0; end
      if (m_WVALID) begin m_WREADY = (wc >= w_delay); wc++; end
      else begin m_WREADY = 1'b0; wc = 0; end
      m_BVALID  = m_BREADY;
      m_ARREADY = m_ARVALID;
      m_RVALID  = m_RREADY;
      if (rd_rand) m_RDATA = (zr_left > 0) ? ($urandom & ~32'h2) : ($urandom | 32'h2);
      else         m_RDATA = (zr_left > 0) ? 32'h0 : 32'h2;
    end
  end

  initial begin : monitor
    bit prev_done;
    logic [8:0] e;
    frame_t f;
    prev_done = 0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        prev_done = 0;
      end else begin
        if (prev_done) begin
          chk("done_single_cycle", done, 0);
          chk("idle_after_done", busy, 0);
        end
        prev_done = done;
        if (start && !busy) ns_idx = cyc;
        if (cyc == ns_idx + 1) begin
          chk("start_clears_ovf", ovf, 0);
          chk("start_clears_in_cnt", in_cnt, 0);
          chk("start_clears_out_cnt", out_cnt, 0);
          chk("busy_after_start", busy, 1);
        end
        if (m_AWVALID && m_AWREADY) begin
          aw_hs++;
          chk("awaddr", m_AWADDR, CTRL_ADDR);
          chk("aw_accept_cycle", cyc - ns_idx, 1 + aw_delay);
        end
        if (m_WVALID && m_WREADY) begin
          w_hs++;
          chk("wdata", m_WDATA, 1);
          chk("wstrb", m_WSTRB, 15);
          chk("w_accept_cycle", cyc - ns_idx, 1 + w_delay);
        end
        if (arg_1_TVALID && !arg_1_TREADY)
          chk("tlast_while_stalled", arg_1_TLAST, (acc_in == IN_BEATS - 1));
        if (arg_1_TVALID && arg_1_TREADY) begin
          chk("in_cnt_track", in_cnt, acc_in);
          if (in_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL in_beat_unexpected actual=beat required=none data=%0d", arg_1_TDATA);
          end else begin
            e = in_q.pop_front();
            chk("in_data", arg_1_TDATA, e[7:0]);
            chk("in_tlast", arg_1_TLAST, e[8]);
            if (e[8]) tl_idx = cyc;
          end
          acc_in++;
        end
        if (arg_0_TVALID && arg_0_TREADY) begin
          out_seen++;
          if (out_seen == OUT_BEATS) out4_idx = cyc;
        end
        if (m_ARVALID && first_ar_idx < 0) begin
          first_ar_idx = cyc;
          chk("poll_after_drain", (tl_idx >= 0) && (out4_idx >= 0), 1);
          chk("first_poll_cycle", cyc, ((tl_idx > out4_idx) ? tl_idx : out4_idx) + 2);
        end
        if (m_ARVALID && m_ARREADY) begin
          ar_hs++;
          chk("araddr", m_ARADDR, CTRL_ADDR);
        end
        if (m_RVALID && m_RREADY && zr_left > 0) zr_left--;
        if (done) begin
          if (fr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected actual=1 required=0");
          end else begin
            f = fr_q.pop_front();
            chk("final_in_cnt", in_cnt, f.in_c);
            chk("final_out_cnt", out_cnt, f.out_c);
            chk("final_ovf", ovf, f.ovf_e);
            chk("poll_reads", ar_hs, f.polls);
            chk("aw_handshakes", aw_hs, 1);
            chk("w_handshakes", w_hs, 1);
            chk("beats_outstanding", in_q.size(), 0);
          end
          frames_done++;
        end
      end
    end
  end

  task automatic recover();
    src_en = 0;
    out_en = 0;
    start = 1'b0;
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    in_q.delete();
    fr_q.delete();
  endtask

  task automatic frame_setup(input int awd, input int wd, input int zr, input int on,
                             input int oa, input int gp, input int tm, input bit rr);
    @(negedge ap_clk);
    #1;
    aw_delay = awd; w_delay = wd; zr_left = zr; out_n = on; out_after = oa;
    gap_pct = gp; tr_mode = tm; rd_rand = rr;
    acc_in = 0; src_k = 0; out_seen = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
    ns_idx = -100; tl_idx = -1; out4_idx = -1; first_ar_idx = -1;
    in_q.delete();
    src_en = 1;
    out_en = 1;
  endtask

  task automatic pulse_start();
    @(posedge ap_clk);
    #1 start = 1'b1;
    @(posedge ap_clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input int awd, input int wd, input int zr, input int on,
                           input int oa, input int gp, input int tm, input bit rr);
    int tgt, i;
    frame_setup(awd, wd, zr, on, oa, gp, tm, rr);
    fr_q.push_back('{IN_BEATS, (on > OUT_BEATS) ? OUT_BEATS : on, (on > OUT_BEATS) ? 1 : 0, zr + 1});
    tgt = frames_done + 1;
    pulse_start();
    i = 0;
    while (frames_done < tgt && i < 2000) begin
      @(negedge ap_clk);
      i++;
    end
    if (frames_done < tgt) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=no_done required=done");
      recover();
    end
    src_en = 0;
    out_en = 0;
    repeat (2) @(posedge ap_clk);
  endtask

  task automatic reset_mid_stream();
    int i;
    frame_setup(0, 0, 0, 0, IN_BEATS, 20, 2, 0);
    pulse_start();
    i = 0;
    while (!(busy && in_cnt == 2) && i < 500) begin @(negedge ap_clk); #1; i++; end
    start = 1'b1;
    i = 0;
    while (!(busy && in_cnt == 7) && i < 500) begin @(negedge ap_clk); #1; i++; end
    chk("reached_in_cnt_7", in_cnt, 7);
    chk("start_ignored_in_cnt", in_cnt + (arg_1_TVALID && arg_1_TREADY), acc_in);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("async_rst_arg1_tvalid", arg_1_TVALID, 0);
    chk("async_rst_src_tready", src_TREADY, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_cnt", in_cnt, 0);
    chk("async_rst_out_cnt", out_cnt, 0);
    start = 1'b0;
    src_en = 0;
    out_en = 0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    in_q.delete();
    repeat (2) @(posedge ap_clk);
  endtask

  initial begin : sequencer
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_outputs",
        {busy, done, ovf, in_cnt, out_cnt, arg_1_TVALID, src_TREADY,
         m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}, 0);
    #2 ap_rst_n = 1'b1;

    run_frame(0, 0, 0, 4, IN_BEATS, 0, 0, 0);   // everything responds at once
    run_frame(3, 0, 0, 4, IN_BEATS, 30, 1, 0);  // AW stall, TREADY toggling, source gaps
    run_frame(0, 0, 2, 4, IN_BEATS, 0, 0, 0);   // two not-done polls
    run_frame(0, 0, 0, 4, 2, 0, 1, 0);          // output finishes during STREAM
    run_frame(0, 0, 0, 5, IN_BEATS, 0, 0, 0);   // one output beat too many
    run_frame(1, 2, 1, 4, 6, 10, 2, 0);         // ovf must clear on this start
    reset_mid_stream();
    run_frame(0, 0, 0, 4, IN_BEATS, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(4, 5), $urandom_range(1, IN_BEATS), $urandom_range(0, 50),
                $urandom_range(0, 2), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_frame_ctrl.md
Name: gb_frame_ctrl

Overview:
- Per-frame sequencer for the Gaussian-blur HLS accelerator (hls_target).
- Starts the core over its AXI4-Lite config slave (ap_start) and gates the input pixel stream onto arg_1 with beat counting and TLAST generation.
- Counts output beats on arg_0, then polls ap_done before reporting frame completion.
- Sits between the frame source/testbench harness and the accelerator core.

Parameters:
- ADDR_W, 5, AXI-Lite address width.
- DATA_W, 32, AXI-Lite data width.
- CNT_W, 20, beat counter width.
- IN_BEATS, 316224, input pixels per frame (488x648).
- OUT_BEATS, 307200, output pixels per frame (480x640).
- CTRL_ADDR, 0, control register address (bit0 ap_start, bit1 ap_done).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- ovf  out  1  sticky: output beat seen after OUT_BEATS; cleared on accepted start.
- in_cnt / out_cnt  out  CNT_W  beats accepted so far this frame.
- src_TDATA  in  8, src_TVALID  in  1, src_TREADY  out  1  pixel source stream.
- arg_1_TDATA  out  8, arg_1_TVALID  out  1, arg_1_TREADY  in  1, arg_1_TLAST  out  1  to the core input.
- arg_0_TVALID  in  1, arg_0_TREADY  in  1  monitors the core output handshake.
- m_AWVALID out 1, m_AWREADY in 1, m_AWADDR out ADDR_W  write address channel.
- m_WVALID out 1, m_WREADY in 1, m_WDATA out DATA_W, m_WSTRB out DATA_W/8  write data channel.
- m_BVALID in 1, m_BREADY out 1  write response channel.
- m_ARVALID out 1, m_ARREADY in 1, m_ARADDR out ADDR_W  read address channel.
- m_RVALID in 1, m_RREADY out 1, m_RDATA in DATA_W  read data channel.

Behaviour:
- Reset (async, ap_rst_n=0): state IDLE; all VALID/READY outputs 0; done=0, ovf=0, busy=0; in_cnt=out_cnt=0.
- Fixed outputs: AWADDR/ARADDR = CTRL_ADDR, WDATA = 32'h1, WSTRB = all ones.
- FSM states: IDLE, CFG_W, CFG_B, STREAM, DRAIN, POLL_AR, POLL_R, DONE.
- IDLE -> CFG_W when start=1. On that edge, clear in_cnt, out_cnt and ovf.
- CFG_W: assert AWVALID and WVALID. Each drops independently once its own READY is seen; both may complete in either order or together. -> CFG_B when both have been accepted.
- CFG_B: BREADY=1. -> STREAM on BVALID. BRESP is ignored.
- STREAM: combinational pass-through.
  - arg_1_TDATA = src_TDATA.
  - arg_1_TVALID = src_TVALID.
  - src_TREADY = arg_1_TREADY.
  - arg_1_TLAST = (in_cnt == IN_BEATS-1).
  - Outside STREAM, arg_1_TVALID=0 and src_TREADY=0.
- An input beat is arg_1_TVALID & arg_1_TREADY; in_cnt increments on each. When the beat with TLAST=1 is accepted -> DRAIN.
- out_cnt increments on arg_0_TVALID & arg_0_TREADY in STREAM and DRAIN, saturating at OUT_BEATS. A beat seen when out_cnt==OUT_BEATS, or in any other state, sets ovf. Output beats may arrive during STREAM.
- Leave DRAIN for POLL_AR on the first cycle in DRAIN with out_cnt==OUT_BEATS. If the count is reached during STREAM, DRAIN exits on its first cycle.
- POLL_AR: ARVALID=1 until ARREADY, then -> POLL_R.
- POLL_R: RREADY=1. On RVALID:
  - RDATA[1]=1 -> DONE.
  - RDATA[1]=0 -> POLL_AR (re-poll, no backoff).
- DONE: done=1 for exactly one cycle, then -> IDLE. busy falls in the same cycle the FSM enters IDLE.
- start in any non-IDLE state is ignored; there is no queueing.
- Reset mid-frame returns immediately to IDLE. The core is not aborted; the next frame requires the core to have been reset externally.
- Counters are CNT_W wide; parameters must satisfy IN_BEATS, OUT_BEATS < 2^CNT_W.

Test Plan:
- Params IN_BEATS=12, OUT_BEATS=4. AWREADY/WREADY/BREADY-path all responding immediately; source always valid; core TREADY=1. Expect:
  - AW and W both accepted one cycle after start;
  - exactly 12 arg_1 beats, with TLAST only on beat 12;
  - 4 output beats, then a poll read returning 0x2;
  - done pulse once; in_cnt=12, out_cnt=4.
- Stalls: AWREADY delayed 3 cycles while WREADY is immediate. arg_1_TREADY toggles 1,0,1,0 and src_TVALID has gaps. Expect:
  - no beat lost or duplicated;
  - TLAST asserted only when in_cnt=11 and held stable while stalled;
  - WVALID deasserts after its own handshake.
- Poll retry: first two reads return RDATA=0x0, the third returns 0x2. Expect three AR handshakes, then done.
- Output beats arrive during STREAM: all 4 arg_0 beats complete before TLAST. Expect no POLL_AR until the input TLAST beat is accepted; DRAIN exits on its first cycle.
- Overflow: 5th arg_0 beat occurs. Expect ovf=1, out_cnt stays at 4, ovf stays high through done, and clears on the next accepted start.
- Async reset asserted mid-STREAM at in_cnt=7. Expect, without waiting for a clock edge:
  - arg_1_TVALID=0, src_TREADY=0, busy=0, counters 0;
  - start held high during STREAM before the reset had no effect.
